// File: rtl/arb_rr4_ctrl.sv
// arb_rr4_ctrl: round-robin arbiter with registered one-hot/encoded grant and hold-time limit.
module arb_rr4_ctrl #(
  parameter int ENCODE_WIDTH = 2,
  parameter int DECODE_WIDTH = 2**ENCODE_WIDTH,
  parameter int MAX_HOLD = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DECODE_WIDTH-1:0] req,
  input  logic                    done,
  output logic [DECODE_WIDTH-1:0] gnt,
  output logic [ENCODE_WIDTH-1:0] gnt_idx,
  output logic                    gnt_valid,
  output logic                    timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state_q, state_d;
  logic [ENCODE_WIDTH-1:0] ptr_q, ptr_d, idx_q, idx_d, win;
  logic [DECODE_WIDTH-1:0] gnt_q, gnt_d;
  logic [7:0] cnt_q, cnt_d;
  logic timeout_q, timeout_d, found, rel;
  always_comb begin
    win = '0;
    found = 1'b0;
    // Scan downwards so the requester closest to ptr wins last.
    for (int i = DECODE_WIDTH - 1; i >= 0; i--) begin
      if (req[(int'(ptr_q) + i) % DECODE_WIDTH]) begin
        win = ENCODE_WIDTH'((int'(ptr_q) + i) % DECODE_WIDTH);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    gnt_d = gnt_q;
    cnt_d = cnt_q;
    timeout_d = 1'b0;
    rel = done || !req[idx_q] || cnt_q == 8'(MAX_HOLD - 1);
    if (state_q == IDLE) begin
      if (found) begin
        state_d = GRANT;
        idx_d = win;
        gnt_d = DECODE_WIDTH'(1) << win;
        ptr_d = ENCODE_WIDTH'((int'(win) + 1) % DECODE_WIDTH);
        cnt_d = '0;
      end
    end else if (rel) begin
      state_d = IDLE;
      idx_d = '0;
      gnt_d = '0;
      cnt_d = '0;
      timeout_d = !done && req[idx_q];
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      idx_q <= '0;
      gnt_q <= '0;
      cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      gnt_q <= gnt_d;
      cnt_q <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign gnt = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_valid = state_q == GRANT;
  assign timeout = timeout_q;
endmodule

// File: tb/tb_arb_rr4_ctrl.sv
// tb_arb_rr4_ctrl: directed checks of grant order, hold limit, release and reset behaviour.
module tb_arb_rr4_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, done = 1'b0;
  logic [3:0] req = 4'b0000, gnt;
  logic [1:0] gnt_idx;
  logic gnt_valid, timeout;
  int n_chk = 0, n_fail = 0;
  arb_rr4_ctrl dut (.clk(clk), .rst_n(rst_n), .req(req), .done(done), .gnt(gnt),
                    .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic outs(input string tag, input logic [3:0] g, input logic [1:0] i, input logic v, input logic t);
    chk({tag, ".gnt"}, 32'(gnt), 32'(g));
    chk({tag, ".idx"}, 32'(gnt_idx), 32'(i));
    chk({tag, ".valid"}, 32'(gnt_valid), 32'(v));
    chk({tag, ".timeout"}, 32'(timeout), 32'(t));
  endtask
  initial begin
    step(); step();
    outs("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    outs("idle_noreq", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b0100;
    step();
    outs("single", 4'b0100, 2'd2, 1'b1, 1'b0);
    done = 1'b1;
    step();
    outs("single_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 1'b0; req = 4'b0000; rst_n = 1'b0;
    step();
    rst_n = 1'b1; req = 4'b1111;
    step();
    outs("fair0", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      done = 1'b1;
      step();
      outs("fair_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
      done = 1'b0;
      step();
      outs("fair_next", 4'b0001 << (k % 4), 2'(k % 4), 1'b1, 1'b0);
    end
    done = 1'b1; req = 4'b0000;
    step();
    done = 1'b0; req = 4'b0001;
    step();
    outs("to_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int k = 1; k < 8; k++) begin
      step();
      chk("to_hold", 32'(gnt), 32'h1);
    end
    step();
    outs("to_pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
    step();
    outs("to_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    step();
    outs("to_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b0010;
    step();
    outs("pre_own1", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b1010;
    step(); step();
    outs("pre_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    outs("pre_to3", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0000;
    step();
    req = 4'b0100;
    step();
    outs("drop_own2", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0000;
    step();
    outs("drop_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b1000;
    step();
    repeat (5) step();
    outs("rst_mid_own3", 4'b1000, 2'd3, 1'b1, 1'b0);
    rst_n = 1'b0;
    step();
    outs("rst_mid", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    outs("rst_regrant", 4'b1000, 2'd3, 1'b1, 1'b0);
    repeat (7) step();
    chk("lim_hold", 32'(gnt), 32'h8);
    done = 1'b1;
    step();
    outs("done_at_limit", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 1'b0; req = 4'b0000;
    step();
    outs("final_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/arb_rr4_ctrl.md
ARB_RR4_CTRL -- requirements
Module: arb_rr4_ctrl

Interface
REQ-001 SHALL have parameter ENCODE_WIDTH, default 2: width of the encoded grant index.
REQ-002 SHALL have parameter DECODE_WIDTH, default 2**ENCODE_WIDTH (4): number of requesters and one-hot grant width.
REQ-003 SHALL have parameter MAX_HOLD, default 8: maximum grant tenure in cycles, legal range 2..255.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port req, input, DECODE_WIDTH: per-requester request, level-sensitive.
REQ-007 SHALL have port done, input, 1: release strobe from the current owner; ignored unless gnt_valid=1.
REQ-008 SHALL have port gnt, output, DECODE_WIDTH: registered one-hot grant, all-zero when no owner.
REQ-009 SHALL have port gnt_idx, output, ENCODE_WIDTH: registered binary index of the owner, 0 when no owner.
REQ-010 SHALL have port gnt_valid, output, 1: registered, high while any gnt bit is set.
REQ-011 SHALL have port timeout, output, 1: registered single-cycle pulse when a grant is revoked by MAX_HOLD.

Function
REQ-012 SHALL implement a two-state FSM: IDLE (no owner) and GRANT (one owner).
REQ-013 SHALL satisfy gnt == one-hot decode of gnt_idx whenever gnt_valid=1, and gnt == 0 whenever gnt_valid=0.
REQ-014 SHALL keep a round-robin pointer ptr (ENCODE_WIDTH bits), reset 0, marking the highest-priority requester.
REQ-015 IDLE, any req bit set: SHALL select the first set bit scanning ptr, ptr+1, ... mod DECODE_WIDTH, then enter GRANT with gnt, gnt_idx and gnt_valid valid on the next edge (1-cycle latency).
REQ-016 IDLE, req == 0: SHALL remain in IDLE with outputs at zero.
REQ-017 On every grant, SHALL set ptr to winner+1 mod DECODE_WIDTH (3 wraps to 0).
REQ-018 GRANT: SHALL hold the owner unchanged; req changes on non-owner bits have no effect.
REQ-019 GRANT: SHALL run a hold counter, cleared to 0 at grant and incremented each GRANT cycle.
REQ-020 GRANT: SHALL release when done=1, when req[gnt_idx]=0, or when the counter equals MAX_HOLD-1.
REQ-021 Release: SHALL return to IDLE on the next edge with gnt=0, gnt_idx=0 and gnt_valid=0, giving exactly one idle cycle between consecutive grants.
REQ-022 Release by counter only (done=0 and req[gnt_idx]=1): SHALL pulse timeout=1 in the same cycle gnt drops; timeout=0 in all other cycles.
REQ-023 Simultaneous done and counter limit: SHALL be a normal release with no timeout pulse.
REQ-024 A timed-out requester that still requests SHALL rejoin arbitration at lowest priority, because ptr has already advanced past it.
REQ-025 SHALL contain no combinational path from req or done to any output.

Reset
REQ-026 With rst_n=0 at a rising edge, SHALL force state=IDLE, ptr=0, hold counter=0, gnt=0, gnt_idx=0, gnt_valid=0 and timeout=0.
REQ-027 Reset asserted mid-grant SHALL drop the grant at that edge with no timeout pulse.
REQ-028 After rst_n rises, arbitration SHALL start from ptr=0 and the first grant SHALL appear no earlier than one edge after req is sampled.

Verification
REQ-029 Single request: after reset, req=0100 held -> next edge gnt=0100, gnt_idx=2, gnt_valid=1; done pulse -> next edge gnt=0000.
REQ-030 Fairness: req=1111 held, done pulsed each grant -> grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-031 Timeout: MAX_HOLD=8, req=0001 held, done=0 -> gnt=0001 for 8 cycles, then gnt=0000 with timeout=1 for 1 cycle, then regrant to 0.
REQ-032 Preemption attempt: owner=1 with req=1010 -> owner stays 1 until release, then grant goes to 3 (ptr=2, bit 2 clear).
REQ-033 Request drop: owner=2, req[2] falls -> next edge gnt=0000 and timeout=0.
REQ-034 Reset mid-grant: owner=3, counter=5, rst_n=0 for one edge -> all outputs 0; req=1000 held -> regrant to 3 one edge after rst_n rises.
